uart_tx_frame: RTL and testbench

- Serial transmitter for the team's 8N1/8E1 UART link; the sending end paired with the existing frame receiver.
- Accepts one parallel byte through a valid/ready handshake and shifts it out LSB-first on a single idle-high line.
- Timing: start bit, data bits, optional even-parity bit, then stop bit.
- Sits between the host-side register logic and the board TX pin; one instance per link.

---
 rtl/uart_tx_frame.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// Serial UART transmitter for the 8N1 / 8E1 link. It accepts one parallel word
// through a valid/ready handshake and shifts it out LSB-first on an idle-high
// line. Each frame is a start bit, DATA_BITS data bits, an optional even-parity
// bit, and a stop bit. Every bit is held for CLKS_PER_BIT clock cycles.
//
// Ports:
//   clk       in   system clock; all state changes on the rising edge
//   rst       in   synchronous, active-high reset
//   tx_data   in   word to send; sampled only on the handshake edge
//   tx_valid  in   host has a word to send
//   tx_ready  out  high only in IDLE; the block can accept a word
//   tx        out  registered serial line, idle high
//   busy      out  registered; high while a frame is in progress
//   done      out  one-cycle pulse in the first IDLE cycle after the stop bit
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cyc_q,   cyc_d;
    logic [BW-1:0]          bit_q,   bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q,   par_d;
    logic                   tx_q,    tx_d;
    logic                   busy_q,  busy_d;
    logic                   done_q,  done_d;

    logic bit_end;

    // Last cycle of the current serial bit.
    assign bit_end = (cyc_q == CYC_LAST);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;

        // The cycle counter runs freely inside a frame and wraps on every
        // bit boundary, so all bit-timed states share it.
        if (state_q != S_IDLE) begin
            cyc_d = bit_end ? '0 : cyc_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // tx_ready is high whenever we are in IDLE, so tx_valid alone
                // completes the handshake here.
                if (tx_valid) begin
                    shift_d = tx_data;
                    par_d   = 1'b0;
                    bit_d   = '0;
                    cyc_d   = '0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);

        // The line level is computed from the *next* state so that the
        // registered tx changes on the same edge as the state register.
        // This gives the 1-cycle handshake-to-start latency with no
        // combinational path from tx_valid to the pin.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, regardless of statement order.
        if (rst) begin
            // NOTE: the shift register and parity accumulator are reset too.
            // They are not observable until a handshake reloads them, but
            // resetting them keeps simulation free of X on tx.
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//
// Directed bench for uart_tx_frame. Two instances with CLKS_PER_BIT=4 and
// DATA_BITS=8 share the stimulus. One has no parity bit and the other has
// even parity. 'sel' picks which instance's outputs are being checked.
//
// The bench checks the line level every cycle against hand-built bit
// sequences. A model receiver samples mid-bit to decode frames for the
// back-to-back and post-reset cases.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;

    logic tx0, rdy0, busy0, done0;
    logic tx1, rdy1, busy1, done1;

    logic sel;
    logic tx_s, rdy_s, busy_s, done_s;

    int n_total = 0;
    int n_bad   = 0;

    // Model receiver state
    bit         rx_en = 1'b0;
    logic [7:0] rx_q[$];
    int         rx_ferr = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0)) u_dut_np (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (rdy0),
        .tx       (tx0),
        .busy     (busy0),
        .done     (done0)
    );

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1)) u_dut_par (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (rdy1),
        .tx       (tx1),
        .busy     (busy1),
        .done     (done1)
    );

    assign tx_s   = sel ? tx1   : tx0;
    assign rdy_s  = sel ? rdy1  : rdy0;
    assign busy_s = sel ? busy1 : busy0;
    assign done_s = sel ? done1 : done0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock. Inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        tx_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
    endtask

    // Send one word and check every cycle of the frame. The task is entered
    // in IDLE and returns in the first IDLE cycle after the stop bit, which is
    // the done cycle. keep_valid leaves tx_valid high with next_d presented.
    // glitch_at >= 0 pulses tx_valid with 0xFF at that frame cycle.
    task automatic frame(input string tag, input logic [7:0] d, input logic exp_par,
                         input bit keep_valid, input logic [7:0] next_d,
                         input int glitch_at);
        logic exp_bits [0:10];
        int   nb;
        nb = sel ? 11 : 10;
        exp_bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) exp_bits[k+1] = d[k];
        exp_bits[9]    = exp_par;
        exp_bits[nb-1] = 1'b1;

        check($sformatf("%s_ready_before", tag), rdy_s, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        for (int i = 0; i < nb * CPB; i++) begin
            if (i == 0) begin
                if (keep_valid) tx_data = next_d;
                else            tx_valid = 1'b0;
            end
            if (i == glitch_at) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
            if (i == glitch_at + 1) begin
                tx_valid = 1'b0;
                tx_data  = d;
            end
            check($sformatf("%s_tx_c%0d", tag, i),    tx_s,   exp_bits[i / CPB]);
            check($sformatf("%s_busy_c%0d", tag, i),  busy_s, 1);
            check($sformatf("%s_ready_c%0d", tag, i), rdy_s,  0);
            check($sformatf("%s_done_c%0d", tag, i),  done_s, 0);
            tick();
        end
        check($sformatf("%s_done_pulse", tag), done_s, 1);
        check($sformatf("%s_ready_end", tag),  rdy_s,  1);
        check($sformatf("%s_busy_end", tag),   busy_s, 0);
        check($sformatf("%s_tx_end", tag),     tx_s,   1);
    endtask

    // Model receiver. It finds the first low cycle and samples each bit
    // mid-way (offset 2 of 4). It checks the parity bit when the parity
    // instance is selected, and checks the stop bit.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rx_en && tx_s === 1'b0) begin
                repeat (2) @(negedge clk);
                if (tx_s !== 1'b0) rx_ferr++;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = tx_s;
                end
                if (sel) begin
                    repeat (CPB) @(negedge clk);
                    if (tx_s !== ^b) rx_ferr++;
                end
                repeat (CPB) @(negedge clk);
                if (tx_s !== 1'b1) rx_ferr++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        sel      = 1'b0;
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;

        // Reset held for 3 cycles while tx_valid is high
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_tx_%0d", i),    tx_s,   1);
            check($sformatf("rst_ready_%0d", i), rdy_s,  1);
            check($sformatf("rst_busy_%0d", i),  busy_s, 0);
            check($sformatf("rst_done_%0d", i),  done_s, 0);
        end
        rst = 1'b0;
        tick();
        // The frame starts only after the first edge with rst low.
        check("rst_release_tx", tx_s, 0);
        check("rst_release_busy", busy_s, 1);
        pulse_reset();

        // Single byte, no parity: 0,1,0,1,0,0,1,0,1,1
        frame("a5", 8'hA5, 1'b0, 1'b0, 8'h00, -10);
        tick();
        check("a5_done_once", done_s, 0);
        check("a5_idle_tx", tx_s, 1);

        // Even parity: A5 has four ones, so parity is 0; 07 has three, so parity is 1.
        sel = 1'b1;
        pulse_reset();
        frame("p_a5", 8'hA5, 1'b0, 1'b0, 8'h00, -10);
        tick();
        frame("p_07", 8'h07, 1'b1, 1'b0, 8'h00, -10);
        tick();

        // Back-to-back frames with tx_valid held high, decoded by the model receiver
        sel = 1'b0;
        pulse_reset();
        rx_q.delete();
        rx_ferr = 0;
        rx_en   = 1'b1;
        frame("b2b_55", 8'h55, 1'b0, 1'b1, 8'h0F, -10);
        frame("b2b_0f", 8'h0F, 1'b0, 1'b0, 8'h00, -10);
        rx_en = 1'b0;
        tick();
        check("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b_rx_0", rx_q[0], 8'h55);
            check("b2b_rx_1", rx_q[1], 8'h0F);
        end
        check("b2b_rx_framing", rx_ferr, 0);

        // tx_valid pulsed with 0xFF in the middle of a 0x00 frame is ignored.
        frame("ign", 8'h00, 1'b0, 1'b0, 8'h00, 15);
        tick();
        check("ign_no_restart_busy", busy_s, 0);
        check("ign_no_restart_tx", tx_s, 1);

        // Reset during DATA bit 3 of 0x3C (frame cycles 16..19)
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (16) tick();
        check("midrst_bit3_before", tx_s, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_tx", tx_s, 1);
        check("midrst_busy", busy_s, 0);
        check("midrst_ready", rdy_s, 1);
        check("midrst_done", done_s, 0);
        for (int i = 0; i < 45; i++) begin
            tick();
            check($sformatf("midrst_quiet_done_%0d", i), done_s, 0);
            check($sformatf("midrst_quiet_tx_%0d", i), tx_s, 1);
        end

        // A following 0x81 transmits cleanly.
        rx_q.delete();
        rx_ferr = 0;
        rx_en   = 1'b1;
        frame("post_81", 8'h81, 1'b0, 1'b0, 8'h00, -10);
        rx_en = 1'b0;
        tick();
        check("post_rx_count", rx_q.size(), 1);
        if (rx_q.size() == 1) check("post_rx_0", rx_q[0], 8'h81);
        check("post_rx_framing", rx_ferr, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
